// File: rtl/itof_pipe.sv
// itof_pipe: pipelined signed 32-bit integer to IEEE-754 single-precision
// converter. It rounds to nearest, with ties going to even.
//
// Pipeline ranks, each with its own valid bit:
//   stage 1 - sign and unsigned magnitude
//   stage 2 - leading-zero count and normalised magnitude
//   stage 3 - exponent, mantissa, guard and sticky fields
//   output  - round, pack and register f
// An operand sampled on edge N shows up on f after edge N+3.
// While stall is high, every rank holds its value.
//
// Ports:
//   clk       in   1  sole clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   in_valid  in   1  operand present on i
//   i         in  32  signed two's-complement operand
//   stall     in   1  freeze the whole pipeline
//   out_valid out  1  f holds a freshly completed result
//   f         out 32  single-precision result
module itof_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] i,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] f
);

  // Leading-zero count. An all-zero input yields a count that is never
  // used, because the zero flag overrides it downstream.
  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int k = 31; k >= 0; k--) begin
      if (found) begin
        n = n;
      end else if (v[k]) begin
        found = 1'b1;
      end else begin
        n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Stage registers
  logic        r_s1_valid, r_s1_sign;
  logic [31:0] r_s1_mag;
  logic        r_s2_valid, r_s2_sign, r_s2_zero;
  logic [4:0]  r_s2_lzc;
  logic [30:0] r_s2_norm;
  logic        r_s3_valid, r_s3_sign, r_s3_zero, r_s3_guard, r_s3_sticky;
  logic [7:0]  r_s3_exp;
  logic [22:0] r_s3_mant;
  logic        r_out_valid;
  logic [31:0] r_f;

  // Combinational stage logic
  logic [31:0] w_mag;
  logic [4:0]  w_lzc;
  logic [31:0] w_norm;
  logic        w_zero;
  logic [7:0]  w_exp;
  logic        w_round_up;
  logic [23:0] w_mant_inc;
  logic [7:0]  w_exp_rnd;
  logic [22:0] w_mant_rnd;
  logic [31:0] w_result;

  // Magnitude. 0 - 0x80000000 wraps to 0x80000000, which is exactly |i|.
  assign w_mag = i[31] ? (32'd0 - i) : i;

  // Normalisation. A nonzero magnitude always lands with bit 31 set, so bit
  // 31 of the shifted value also serves as the zero detector.
  assign w_lzc  = lzc32(r_s1_mag);
  assign w_norm = r_s1_mag << w_lzc;
  assign w_zero = ~w_norm[31];

  // The biased exponent of 2^(31-lzc) is 127 + 31 - lzc.
  assign w_exp = 8'd158 - {3'b000, r_s2_lzc};

  // Round-to-nearest-even and pack the final word.
  assign w_round_up = r_s3_guard & (r_s3_sticky | r_s3_mant[0]);
  assign w_mant_inc = {1'b0, r_s3_mant} + 24'd1;

  // Select the rounded mantissa and exponent. A carry out of the mantissa
  // means the value reached the next power of two.
  always_comb begin
    w_exp_rnd  = r_s3_exp;
    w_mant_rnd = r_s3_mant;
    if (w_round_up) begin
      if (w_mant_inc[23]) begin
        w_mant_rnd = 23'd0;
        w_exp_rnd  = r_s3_exp + 8'd1;
      end else begin
        w_mant_rnd = w_mant_inc[22:0];
        w_exp_rnd  = r_s3_exp;
      end
    end else begin
      w_mant_rnd = r_s3_mant;
      w_exp_rnd  = r_s3_exp;
    end
  end

  // Pack the result. A zero operand always packs as positive zero.
  always_comb begin
    w_result = 32'd0;
    if (r_s3_zero) begin
      w_result = 32'd0;
    end else begin
      w_result = {r_s3_sign, w_exp_rnd, w_mant_rnd};
    end
  end

  // Pipeline ranks: cleared by reset, frozen by stall. f only changes when a
  // valid result arrives, so it holds the last result between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_mag    <= 32'd0;
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_lzc    <= 5'd0;
      r_s2_norm   <= 31'd0;
      r_s3_valid  <= 1'b0;
      r_s3_sign   <= 1'b0;
      r_s3_zero   <= 1'b0;
      r_s3_exp    <= 8'd0;
      r_s3_mant   <= 23'd0;
      r_s3_guard  <= 1'b0;
      r_s3_sticky <= 1'b0;
      r_out_valid <= 1'b0;
      r_f         <= 32'd0;
    end else if (!stall) begin
      r_s1_valid  <= in_valid;
      r_s1_sign   <= i[31];
      r_s1_mag    <= w_mag;
      r_s2_valid  <= r_s1_valid;
      r_s2_sign   <= r_s1_sign;
      r_s2_zero   <= w_zero;
      r_s2_lzc    <= w_lzc;
      r_s2_norm   <= w_norm[30:0];
      r_s3_valid  <= r_s2_valid;
      r_s3_sign   <= r_s2_sign;
      r_s3_zero   <= r_s2_zero;
      r_s3_exp    <= w_exp;
      r_s3_mant   <= r_s2_norm[30:8];
      r_s3_guard  <= r_s2_norm[7];
      r_s3_sticky <= |r_s2_norm[6:0];
      r_out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_f <= w_result;
      end else begin
        r_f <= r_f;
      end
    end else begin
      r_out_valid <= r_out_valid;
      r_f         <= r_f;
    end
  end

  assign out_valid = r_out_valid;
  assign f         = r_f;

endmodule
